// File: rtl/valid_ready_reorder_buffer.sv
// -----------------------------------------------------------------------------
// valid_ready_reorder_buffer
//
// Restores issue order for transactions whose responses come back out of
// order. A requester reserves a slot in order and carries the granted index as
// a tag. The response is later written back by that index, in any order. The
// read side releases data strictly in reservation order, as soon as the oldest
// reserved entry has been filled.
//
// Ports
//   clock          rising-edge clock
//   resetn         asynchronous active-low reset
//   full / empty   occupancy flags, decoded from the registered count
//   reserve_*      reserve handshake; reserve_index is the granted slot
//   write_*        response write-back by index; write_error flags a dropped
//                  write (index out of range, not reserved, or already filled)
//   read_*         in-order drain of the oldest entry
// -----------------------------------------------------------------------------
module valid_ready_reorder_buffer #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 8,
  parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   resetn,
  output logic                   full,
  output logic                   empty,
  input  logic                   reserve_valid,
  output logic                   reserve_ready,
  output logic [INDEX_WIDTH-1:0] reserve_index,
  input  logic                   write_valid,
  input  logic [INDEX_WIDTH-1:0] write_index,
  input  logic [WIDTH-1:0]       write_data,
  output logic                   write_ready,
  output logic                   write_error,
  output logic                   read_valid,
  output logic [WIDTH-1:0]       read_data,
  input  logic                   read_ready
);

  localparam int CNT_WIDTH = $clog2(DEPTH + 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX  = INDEX_WIDTH'(DEPTH - 1);
  localparam logic [INDEX_WIDTH:0]   DEPTH_IDX = (INDEX_WIDTH + 1)'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]   DEPTH_CNT = CNT_WIDTH'(DEPTH);

  logic [DEPTH-1:0]       r_reserved;
  logic [DEPTH-1:0]       r_filled;
  logic [WIDTH-1:0]       r_data [DEPTH];
  logic [INDEX_WIDTH-1:0] r_res_ptr;
  logic [INDEX_WIDTH-1:0] r_rd_ptr;
  logic [CNT_WIDTH-1:0]   r_count;

  logic w_reserve_hs;
  logic w_read_hs;
  logic w_index_ok;
  logic w_write_ok;

  // Pointers wrap at DEPTH-1, so non-power-of-two depths never produce an
  // index >= DEPTH.
  function automatic logic [INDEX_WIDTH-1:0] f_next(input logic [INDEX_WIDTH-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign full          = (r_count == DEPTH_CNT);
  assign empty         = (r_count == '0);
  assign reserve_ready = ~full;
  assign reserve_index = r_res_ptr;
  assign write_ready   = 1'b1;

  // A write is legal only into a reserved, still-unfilled slot. The slot being
  // reserved this cycle is not yet reserved, and the head being read is
  // already filled, so both same-cycle collisions are flagged here without any
  // extra logic.
  assign w_index_ok  = ({1'b0, write_index} < DEPTH_IDX);
  assign w_write_ok  = write_valid & w_index_ok & r_reserved[write_index] & ~r_filled[write_index];
  assign write_error = write_valid & ~w_write_ok;

  // Head-of-line: only the read-pointer entry is visible. Filled entries
  // behind an unfilled head stay hidden. An empty buffer has no filled flags,
  // so read_valid is low then.
  assign read_valid = r_filled[r_rd_ptr];
  assign read_data  = r_data[r_rd_ptr];

  assign w_reserve_hs = reserve_valid & reserve_ready;
  assign w_read_hs    = read_valid & read_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // update below sees the pre-edge values and statement order does not matter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_reserved <= '0;
      r_filled   <= '0;
      r_res_ptr  <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      // NOTE: the data array is reset as well, because read_data must read
      // zero straight out of reset. A reset-free RAM would leave it undefined.
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else begin
      if (w_reserve_hs) begin
        r_reserved[r_res_ptr] <= 1'b1;
        r_filled[r_res_ptr]   <= 1'b0;
        r_res_ptr             <= f_next(r_res_ptr);
      end
      if (w_write_ok) begin
        r_filled[write_index] <= 1'b1;
        r_data[write_index]   <= write_data;
      end
      // The reserve slot is never the read slot here: equal pointers mean
      // empty (no read) or full (no reserve).
      if (w_read_hs) begin
        r_reserved[r_rd_ptr] <= 1'b0;
        r_filled[r_rd_ptr]   <= 1'b0;
        r_rd_ptr             <= f_next(r_rd_ptr);
      end
      unique case ({w_reserve_hs, w_read_hs})
        2'b10:   r_count <= r_count + CNT_WIDTH'(1);
        2'b01:   r_count <= r_count - CNT_WIDTH'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_valid_ready_reorder_buffer.sv
// -----------------------------------------------------------------------------
// Testbench for valid_ready_reorder_buffer.
//
// Two instances are used: DEPTH=4 and DEPTH=6, both with WIDTH=8. They share
// stimulus, and `sel` gates the valid and ready inputs to the active one.
//
// The reference model is an ordered queue of reserved indices plus per-index
// filled/data tables. Every cycle the model predicts all outputs and then
// applies the handshakes it expects.
// -----------------------------------------------------------------------------
module tb_valid_ready_reorder_buffer;

  logic       clock = 1'b0;
  logic       resetn;
  logic       sel;
  logic       rv, wv, rr;
  logic [2:0] wi;
  logic [7:0] wd;

  always #5 clock = ~clock;

  logic       full4, empty4, rrdy4, wrdy4, werr4, rvld4;
  logic [1:0] ridx4;
  logic [7:0] rdat4;
  logic       full6, empty6, rrdy6, wrdy6, werr6, rvld6;
  logic [2:0] ridx6;
  logic [7:0] rdat6;

  valid_ready_reorder_buffer #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clock(clock), .resetn(resetn), .full(full4), .empty(empty4),
    .reserve_valid(rv & ~sel), .reserve_ready(rrdy4), .reserve_index(ridx4),
    .write_valid(wv & ~sel), .write_index(wi[1:0]), .write_data(wd),
    .write_ready(wrdy4), .write_error(werr4),
    .read_valid(rvld4), .read_data(rdat4), .read_ready(rr & ~sel)
  );

  valid_ready_reorder_buffer #(.WIDTH(8), .DEPTH(6)) u_dut6 (
    .clock(clock), .resetn(resetn), .full(full6), .empty(empty6),
    .reserve_valid(rv & sel), .reserve_ready(rrdy6), .reserve_index(ridx6),
    .write_valid(wv & sel), .write_index(wi), .write_data(wd),
    .write_ready(wrdy6), .write_error(werr6),
    .read_valid(rvld6), .read_data(rdat6), .read_ready(rr & sel)
  );

  logic       o_full, o_empty, o_rrdy, o_wrdy, o_werr, o_rvld;
  logic [2:0] o_ridx;
  logic [7:0] o_rdat;

  assign o_full  = sel ? full6  : full4;
  assign o_empty = sel ? empty6 : empty4;
  assign o_rrdy  = sel ? rrdy6  : rrdy4;
  assign o_wrdy  = sel ? wrdy6  : wrdy4;
  assign o_werr  = sel ? werr6  : werr4;
  assign o_rvld  = sel ? rvld6  : rvld4;
  assign o_ridx  = sel ? ridx6  : {1'b0, ridx4};
  assign o_rdat  = sel ? rdat6  : rdat4;

  // Reference model state.
  int         depth;
  int         q[$];
  bit         fil[8];
  logic [7:0] dat[8];
  int         next_res;
  logic [7:0] got_q[$];

  // Outputs observed in the most recent cycle.
  logic       l_full, l_empty, l_rrdy, l_werr, l_rvld;
  logic [2:0] l_ridx;
  logic [7:0] l_rdat;
  bit         l_rhs;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_q(input int idx);
    foreach (q[k]) if (q[k] == idx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset(input int d);
    depth    = d;
    next_res = 0;
    q.delete();
    for (int i = 0; i < 8; i++) begin
      fil[i] = 1'b0;
      dat[i] = 8'h00;
    end
  endtask

  task automatic reset_outputs_check(input string tag);
    check({tag, "_full"},    o_full,  0);
    check({tag, "_empty"},   o_empty, 1);
    check({tag, "_rrdy"},    o_rrdy,  1);
    check({tag, "_ridx"},    o_ridx,  0);
    check({tag, "_wrdy"},    o_wrdy,  1);
    check({tag, "_werr"},    o_werr,  0);
    check({tag, "_rvalid"},  o_rvld,  0);
    check({tag, "_rdata"},   o_rdat,  0);
  endtask

  // One clock cycle:
  //   1. drive inputs at the falling edge;
  //   2. compare outputs against the model;
  //   3. advance the model by the handshakes it predicts for the next rising
  //      edge.
  task automatic cycle(input bit rv_i, input bit wv_i, input logic [2:0] wi_i,
                       input logic [7:0] wd_i, input bit rr_i);
    bit e_full, e_empty, e_werr, e_rvld, wr_ok, res_hs, rd_hs;
    int wix, h;
    @(negedge clock);
    rv = rv_i; wv = wv_i; wi = wi_i; wd = wd_i; rr = rr_i;
    #1;
    wix     = int'(wi_i);
    e_full  = (q.size() == depth);
    e_empty = (q.size() == 0);
    wr_ok   = wv_i && (wix < depth) && in_q(wix) && !fil[wix];
    e_werr  = wv_i && !wr_ok;
    e_rvld  = !e_empty && fil[q[0]];
    l_full = o_full; l_empty = o_empty; l_rrdy = o_rrdy; l_werr = o_werr;
    l_rvld = o_rvld; l_ridx = o_ridx; l_rdat = o_rdat;
    check("full",          o_full,  e_full);
    check("empty",         o_empty, e_empty);
    check("reserve_ready", o_rrdy,  !e_full);
    check("reserve_index", o_ridx,  next_res);
    check("write_ready",   o_wrdy,  1);
    check("write_error",   o_werr,  e_werr);
    check("read_valid",    o_rvld,  e_rvld);
    if (e_rvld) check("read_data", o_rdat, dat[q[0]]);
    res_hs = rv_i && !e_full;
    rd_hs  = rr_i && e_rvld;
    l_rhs  = rd_hs;
    if (rd_hs) begin
      got_q.push_back(o_rdat);
      h = q.pop_front();
      fil[h] = 1'b0;
    end
    if (wr_ok) begin
      fil[wix] = 1'b1;
      dat[wix] = wd_i;
    end
    if (res_hs) begin
      q.push_back(next_res);
      fil[next_res] = 1'b0;
      next_res = (next_res + 1) % depth;
    end
  endtask

  // Random cycle. Writes mostly target reserved entries, so that fills
  // actually happen; the rest pick any index up to wmax.
  task automatic rnd_cycle(input int wmax);
    bit         rvb, wvb, rrb;
    logic [2:0] wix;
    rvb = 1'($urandom_range(0, 1));
    wvb = ($urandom_range(0, 2) != 0);
    rrb = ($urandom_range(0, 3) != 0);
    if (q.size() > 0 && $urandom_range(0, 3) != 0)
      wix = 3'(q[$urandom_range(0, q.size() - 1)]);
    else
      wix = 3'($urandom_range(0, wmax));
    cycle(rvb, wvb, wix, 8'($urandom), rrb);
  endtask

  initial begin : stim
    logic [7:0] exp_order[4];
    bit         saw_wrap;
    logic [2:0] prev_idx;
    int         uf;

    exp_order = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    sel = 1'b0; rv = 1'b0; wv = 1'b0; rr = 1'b0; wi = '0; wd = '0;
    resetn = 1'b0;
    model_reset(4);

    // Reset state.
    #12;
    reset_outputs_check("reset");
    @(negedge clock);
    resetn = 1'b1;

    // Reserve 4 slots: indexes 0..3, then full blocks a 5th reserve.
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0, 0);
      check("plan_reserve_idx", l_ridx, i);
    end
    cycle(1, 0, 0, 0, 0);
    check("plan_full_blocks", {l_full, l_rrdy}, 2'b10);

    // Out-of-order writes 2, 0, 3, 1 with read_ready held high.
    got_q.delete();
    cycle(0, 1, 2, 8'hC2, 1);
    cycle(0, 1, 0, 8'hA0, 1);
    cycle(0, 1, 3, 8'hD3, 1);
    check("plan_a0_valid", l_rvld, 1);
    check("plan_a0_data",  l_rdat, 8'hA0);
    cycle(0, 1, 1, 8'hB1, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 1);
      check("plan_drain_hs", l_rhs, 1);
    end
    cycle(0, 0, 0, 0, 1);
    check("plan_empty_end", l_empty, 1);
    check("plan_order_len", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check("plan_order", got_q[i], exp_order[i]);

    // Write to an unreserved index.
    cycle(0, 1, 1, 8'hEE, 0);
    check("plan_unreserved_err", l_werr, 1);
    // Reserve idx0, then write into the slot being reserved this same cycle.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 8'h77, 0);
    check("plan_write_reserving_err", l_werr, 1);
    // Double write: the second write is flagged and the first data is kept.
    cycle(0, 1, 0, 8'h11, 0);
    cycle(0, 1, 0, 8'h22, 0);
    check("plan_double_write_err", l_werr, 1);
    // Read head and write a different entry in the same cycle.
    cycle(0, 1, 1, 8'h33, 1);
    check("plan_first_data_kept", l_rdat, 8'h11);
    check("plan_write_other_ok", l_werr, 0);
    // Write to the entry being read in the same cycle.
    cycle(0, 1, 1, 8'h44, 1);
    check("plan_write_reading_err", l_werr, 1);
    check("plan_read_data_33", l_rdat, 8'h33);

    // Backpressure: the head holds for 3 stalled cycles.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 3'(q[0]), 8'h5A, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0);
      check("plan_bp_valid", l_rvld, 1);
      check("plan_bp_data",  l_rdat, 8'h5A);
    end
    cycle(0, 0, 0, 0, 1);
    check("plan_bp_consumed", l_rhs, 1);
    cycle(0, 0, 0, 0, 0);
    check("plan_bp_empty", l_empty, 1);

    for (int i = 0; i < 300; i++) rnd_cycle(3);

    // Switch to the DEPTH=6 instance, which has stayed idle in reset state.
    rv = 1'b0; wv = 1'b0; rr = 1'b0; sel = 1'b1;
    model_reset(6);

    cycle(0, 1, 6, 8'h66, 0);
    check("plan_idx6_err", l_werr, 1);
    cycle(0, 1, 7, 8'h77, 0);
    check("plan_idx7_err", l_werr, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, 0, 0, 0);
      check("plan6_reserve_idx", l_ridx, i);
    end
    for (int i = 0; i < 6; i++) cycle(0, 1, 3'(i), 8'h10 + 8'(i), 0);
    cycle(1, 0, 0, 0, 1);
    check("plan6_full", {l_full, l_rrdy}, 2'b10);

    // Steady state: reserve and read every cycle for 20 cycles. Each cycle
    // also fills the slot reserved on the previous cycle.
    got_q.delete();
    saw_wrap = 1'b0;
    prev_idx = 3'd0;
    for (int k = 0; k < 20; k++) begin
      cycle(1, !fil[q[q.size() - 1]], 3'(q[q.size() - 1]), 8'h80 + 8'(k), 1);
      check("steady_not_full",  l_full,  0);
      check("steady_not_empty", l_empty, 0);
      check("steady_read_hs",   l_rhs,   1);
      if (k > 0 && prev_idx == 3'd5 && l_ridx == 3'd0) saw_wrap = 1'b1;
      prev_idx = l_ridx;
    end
    check("steady_wrap_5_to_0", saw_wrap, 1);
    check("steady_order_len", got_q.size(), 20);
    for (int k = 0; k < 20 && k < got_q.size(); k++)
      check("steady_order", got_q[k], (k < 5) ? 8'h11 + 8'(k) : 8'h80 + 8'(k - 4));

    for (int i = 0; i < 300; i++) rnd_cycle(7);

    // Drain (bounded): keep filling the oldest unfilled entry and reading.
    for (int n = 0; n < 40 && q.size() > 0; n++) begin
      uf = -1;
      foreach (q[k]) if (uf < 0 && !fil[q[k]]) uf = q[k];
      cycle(0, uf >= 0, 3'((uf < 0) ? 0 : uf), 8'($urandom), 1);
    end
    check("drain_done", q.size(), 0);

    // Asynchronous reset mid-cycle with 3 filled entries.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 3'(q[i]), 8'hE0 + 8'(i), 0);
    cycle(0, 0, 0, 0, 0);
    check("pre_reset_valid", l_rvld, 1);
    @(posedge clock);
    #2;
    rv = 1'b0; wv = 1'b0; rr = 1'b0;
    #1;
    resetn = 1'b0;
    #1;
    reset_outputs_check("midreset");
    @(negedge clock);
    resetn = 1'b1;
    model_reset(6);
    cycle(1, 0, 0, 0, 0);
    check("post_reset_first_idx", l_ridx, 0);
    cycle(0, 0, 0, 0, 1);
    check("post_reset_no_residual", l_rvld, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
